// File: rtl/sz_pkg.sv
// sz_pkg
// Shared encodings for the predictive quantizer:
//   - result codes driven on out_code
//   - prediction mode encodings sampled from the mode input
//   - history-depth saturation helper used when a channel's history advances
package sz_pkg;

    // Result codes
    localparam logic [1:0] CODE_PRED   = 2'b00;
    localparam logic [1:0] CODE_UNPRED = 2'b01;
    localparam logic [1:0] CODE_BYPASS = 2'b10;

    // Prediction modes; the spare encoding behaves like order-0
    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'b00,
        MODE_ORD0     = 2'b01,
        MODE_ORD1     = 2'b10,
        MODE_ORD0_ALT = 2'b11
    } mode_e;

    // History depth saturates at two stored reconstructions
    localparam logic [1:0] HCNT_MAX = 2'd2;

    function automatic logic [1:0] hcnt_next(input logic [1:0] h);
        return (h >= HCNT_MAX) ? HCNT_MAX : h + 2'd1;
    endfunction

endpackage

// File: rtl/sz_quantizer.sv
// sz_quantizer
// Purely combinational prediction + error-bounded quantization of one sample.
// Ports:
//   p1, p2   in  WIDTH  last and second-to-last reconstructed values of the channel
//   hcnt     in  2      effective history depth (0..2), already forced to 0 on block start
//   order1   in  1      1 = linear prediction, 0 = previous-value prediction
//   in_data  in  WIDTH  signed sample
//   q        out QBITS  signed quantization code (0 when unpredictable)
//   code     out 2      CODE_PRED or CODE_UNPRED
//   recon    out WIDTH  value the decoder will reconstruct (becomes the new p1)
module sz_quantizer
    import sz_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int QBITS    = 16,
    parameter int EB_SHIFT = 4
) (
    input  logic [WIDTH-1:0] p1,
    input  logic [WIDTH-1:0] p2,
    input  logic [1:0]       hcnt,
    input  logic             order1,
    input  logic [WIDTH-1:0] in_data,
    output logic [QBITS-1:0] q,
    output logic [1:0]       code,
    output logic [WIDTH-1:0] recon
);

    // One guard bit beyond WIDTH+2 so that diff + half-bin cannot wrap even
    // for the most extreme linear prediction.
    localparam int XW = WIDTH + 3;

    localparam logic signed [XW-1:0] ONE      = 1;
    localparam logic signed [XW-1:0] HALF_BIN = ONE <<< EB_SHIFT;
    localparam logic signed [XW-1:0] QMAX     = (ONE <<< (QBITS - 1)) - ONE;
    // Symmetric range: the most negative QBITS code is never emitted
    localparam logic signed [XW-1:0] QMIN     = -QMAX;

    logic signed [XW-1:0] p1_x;
    logic signed [XW-1:0] p2_x;
    logic signed [XW-1:0] d_x;
    logic signed [XW-1:0] pred;
    logic signed [XW-1:0] diff;
    logic signed [XW-1:0] q_x;

    always_comb begin
        p1_x  = XW'($signed(p1));
        p2_x  = XW'($signed(p2));
        d_x   = XW'($signed(in_data));
        pred  = '0;
        q     = '0;
        code  = CODE_UNPRED;
        recon = in_data;

        if (hcnt != 2'd0) begin
            if (order1 && (hcnt == HCNT_MAX)) begin
                pred = (p1_x <<< 1) - p2_x;
            end else begin
                pred = p1_x;
            end
        end

        diff = d_x - pred;
        // Round-to-nearest bin: arithmetic shift floors toward -inf
        q_x  = (diff + HALF_BIN) >>> (EB_SHIFT + 1);

        if ((q_x <= QMAX) && (q_x >= QMIN)) begin
            code  = CODE_PRED;
            q     = q_x[QBITS-1:0];
            // Wraps modulo 2^WIDTH exactly as the decoder will
            recon = pred[WIDTH-1:0] + (q_x[WIDTH-1:0] << (EB_SHIFT + 1));
        end
    end

endmodule

// File: rtl/sz_pred_quant.sv
// sz_pred_quant
// Two-stage predictive quantizer for NCH interleaved channels of signed samples.
// S1 captures the incoming sample; the quantizer works on S1 against the
// channel history; S2 is the output register. History is written on the same
// edge that loads S2, so the next same-channel sample sitting in S1 reads the
// updated registers without any forwarding.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mode                00 bypass, 01 order-0, 10 order-1, 11 order-0
//   in_valid/in_ready   input handshake
//   in_data, in_ch      sample and its channel
//   in_block_start      clears that channel's history for this sample
//   out_valid/out_ready output handshake
//   out_code            00 predictable, 01 unpredictable, 10 bypass
//   out_quant           quant code (code 00 only)
//   out_raw             original sample (codes 01/10 only)
//   out_ch              channel of the result
//   cnt_clr             synchronous clear of cnt_unpred
//   cnt_unpred          saturating count of unpredictable results
module sz_pred_quant
    import sz_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int QBITS    = 16,
    parameter int NCH      = 4,
    parameter int EB_SHIFT = 4,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CHW-1:0]   in_ch,
    input  logic             in_block_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic [QBITS-1:0] out_quant,
    output logic [WIDTH-1:0] out_raw,
    output logic [CHW-1:0]   out_ch,
    input  logic             cnt_clr,
    output logic [31:0]      cnt_unpred
);

    // S1 stage
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [CHW-1:0]   s1_ch_q,    s1_ch_d;
    logic             s1_bs_q,    s1_bs_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;

    // S2 stage
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_code_q,  out_code_d;
    logic [QBITS-1:0] out_quant_q, out_quant_d;
    logic [WIDTH-1:0] out_raw_q,   out_raw_d;
    logic [CHW-1:0]   out_ch_q,    out_ch_d;

    // Per-channel history
    logic [WIDTH-1:0] p1_q   [NCH];
    logic [WIDTH-1:0] p1_d   [NCH];
    logic [WIDTH-1:0] p2_q   [NCH];
    logic [WIDTH-1:0] p2_d   [NCH];
    logic [1:0]       hcnt_q [NCH];
    logic [1:0]       hcnt_d [NCH];

    logic [31:0]      cnt_q, cnt_d;

    // Handshake / datapath nets
    logic             s2_load;
    logic             s1_adv;
    logic             s1_load;
    logic             in_ready_c;
    logic             bypass;
    logic             order1;
    logic [WIDTH-1:0] hist_p1;
    logic [WIDTH-1:0] hist_p2;
    logic [1:0]       hcnt_eff;
    logic [QBITS-1:0] qz_q;
    logic [1:0]       qz_code;
    logic [WIDTH-1:0] qz_recon;

    always_comb begin
        s2_load    = !out_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_load;
        in_ready_c = !s1_valid_q || s2_load;
        s1_load    = in_valid && in_ready_c;

        bypass     = (s1_mode_q == MODE_BYPASS);
        order1     = (s1_mode_q == MODE_ORD1);
        hist_p1    = p1_q[s1_ch_q];
        hist_p2    = p2_q[s1_ch_q];
        hcnt_eff   = s1_bs_q ? 2'd0 : hcnt_q[s1_ch_q];
    end

    sz_quantizer #(
        .WIDTH    (WIDTH),
        .QBITS    (QBITS),
        .EB_SHIFT (EB_SHIFT)
    ) u_quant (
        .p1      (hist_p1),
        .p2      (hist_p2),
        .hcnt    (hcnt_eff),
        .order1  (order1),
        .in_data (s1_data_q),
        .q       (qz_q),
        .code    (qz_code),
        .recon   (qz_recon)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_ch_d    = s1_ch_q;
        s1_bs_d    = s1_bs_q;
        s1_mode_d  = s1_mode_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_ch_d    = in_ch;
            s1_bs_d    = in_block_start;
            s1_mode_d  = mode;
        end else if (s2_load) begin
            // Either already empty or its sample just moved into S2
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_quant_d = out_quant_q;
        out_raw_d   = out_raw_q;
        out_ch_d    = out_ch_q;

        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_ch_d = s1_ch_q;
                if (bypass) begin
                    out_code_d  = CODE_BYPASS;
                    out_quant_d = '0;
                    out_raw_d   = s1_data_q;
                end else if (qz_code == CODE_PRED) begin
                    out_code_d  = CODE_PRED;
                    out_quant_d = qz_q;
                    out_raw_d   = '0;
                end else begin
                    out_code_d  = CODE_UNPRED;
                    out_quant_d = '0;
                    out_raw_d   = s1_data_q;
                end
            end
        end
    end

    always_comb begin
        p1_d   = p1_q;
        p2_d   = p2_q;
        hcnt_d = hcnt_q;

        if (s1_adv && !bypass) begin
            p2_d[s1_ch_q]   = s1_bs_q ? '0 : hist_p1;
            p1_d[s1_ch_q]   = qz_recon;
            hcnt_d[s1_ch_q] = hcnt_next(hcnt_eff);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s1_adv && !bypass && (qz_code == CODE_UNPRED) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_ch_q     <= '0;
            s1_bs_q     <= 1'b0;
            s1_mode_q   <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_quant_q <= '0;
            out_raw_q   <= '0;
            out_ch_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < NCH; i++) begin
                p1_q[i]   <= '0;
                p2_q[i]   <= '0;
                hcnt_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_ch_q     <= s1_ch_d;
            s1_bs_q     <= s1_bs_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_quant_q <= out_quant_d;
            out_raw_q   <= out_raw_d;
            out_ch_q    <= out_ch_d;
            cnt_q       <= cnt_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            hcnt_q      <= hcnt_d;
        end
    end

    assign in_ready   = in_ready_c;
    assign out_valid  = out_valid_q;
    assign out_code   = out_code_q;
    assign out_quant  = out_quant_q;
    assign out_raw    = out_raw_q;
    assign out_ch     = out_ch_q;
    assign cnt_unpred = cnt_q;

endmodule

// File: tb/tb_sz_pred_quant.sv
module tb_sz_pred_quant;

    localparam int WIDTH    = 32;
    localparam int QBITS    = 16;
    localparam int NCH      = 4;
    localparam int EB_SHIFT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_ch;
    logic        in_block_start;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_code;
    logic [15:0] out_quant;
    logic [31:0] out_raw;
    logic [1:0]  out_ch;
    logic        cnt_clr;
    logic [31:0] cnt_unpred;

    always #5 clk = ~clk;

    sz_pred_quant #(
        .WIDTH(WIDTH), .QBITS(QBITS), .NCH(NCH), .EB_SHIFT(EB_SHIFT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_ch          (in_ch),
        .in_block_start (in_block_start),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_code       (out_code),
        .out_quant      (out_quant),
        .out_raw        (out_raw),
        .out_ch         (out_ch),
        .cnt_clr        (cnt_clr),
        .cnt_unpred     (cnt_unpred)
    );

    typedef struct packed {
        logic [1:0]  code;
        logic [15:0] quant;
        logic [31:0] raw;
        logic [1:0]  ch;
    } res_t;

    typedef struct {
        logic        bs;
        logic [1:0]  ch;
        logic [1:0]  md;
        logic [31:0] data;
        logic [1:0]  code;
        logic [15:0] quant;
        logic [31:0] raw;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    longint m_p1 [NCH];
    longint m_p2 [NCH];
    int     m_h  [NCH];
    longint m_cnt;
    res_t   exp_q [$];
    res_t   obs_q [$];
    vec_t   tbl   [$];
    bit     took;
    bit     hold_prev;
    logic [52:0] hold_val;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_p1[i] = 0;
            m_p2[i] = 0;
            m_h[i]  = 0;
        end
        m_cnt = 0;
    endfunction

    // Reference: prediction, rounding to the nearest bin by floor division,
    // symmetric code range, and reconstruction kept modulo 2^32.
    function automatic res_t model(logic bs, logic [1:0] ch, logic [1:0] md, logic [31:0] data);
        res_t   r;
        longint d, pred, diff, num, bin, q, qlim, recon;
        int     h;
        r.code  = 2'b00;
        r.ch    = ch;
        r.quant = '0;
        r.raw   = '0;
        d = longint'($signed(data));
        if (md == 2'b00) begin
            r.code = 2'b10;
            r.raw  = data;
            return r;
        end
        h = bs ? 0 : m_h[ch];
        if (h == 0)                      pred = 0;
        else if (md == 2'b10 && h == 2)  pred = 2 * m_p1[ch] - m_p2[ch];
        else                             pred = m_p1[ch];
        diff = d - pred;
        bin  = 2 ** (EB_SHIFT + 1);
        num  = diff + bin / 2;
        q    = num / bin;
        if ((num % bin != 0) && (num < 0)) q = q - 1;
        qlim = 2 ** (QBITS - 1) - 1;
        if (q >= -qlim && q <= qlim) begin
            r.code  = 2'b00;
            r.quant = 16'(q);
            recon   = longint'($signed(32'(pred + q * bin)));
        end else begin
            r.code = 2'b01;
            r.raw  = data;
            recon  = d;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        m_p2[ch] = bs ? 0 : m_p1[ch];
        m_p1[ch] = recon;
        m_h[ch]  = (h < 2) ? h + 1 : 2;
        return r;
    endfunction

    function automatic void add(int bs, int ch, int md, int data, int code, int q, int raw);
        vec_t v;
        v.bs    = 1'(bs);
        v.ch    = 2'(ch);
        v.md    = 2'(md);
        v.data  = 32'(data);
        v.code  = 2'(code);
        v.quant = 16'(q);
        v.raw   = 32'(raw);
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, score them, return just after the rising edge.
    task automatic tick();
        res_t got;
        res_t e;
        @(negedge clk);
        took = 1'b0;
        if (hold_prev) begin
            n_vec++;
            if ({out_valid, out_code, out_quant, out_raw, out_ch} !== hold_val) begin
                n_err++;
                $display("FAIL hold: outputs %h changed from %h while stalled",
                         {out_valid, out_code, out_quant, out_raw, out_ch}, hold_val);
            end
        end
        hold_prev = out_valid && !out_ready;
        hold_val  = {out_valid, out_code, out_quant, out_raw, out_ch};
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_block_start, in_ch, mode, in_data));
            took = 1'b1;
        end
        if (out_valid && out_ready) begin
            got = {out_code, out_quant, out_raw, out_ch};
            obs_q.push_back(got);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: code=%0d ch=%0d with nothing expected", out_code, out_ch);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL result: got code=%0d q=%0d raw=%h ch=%0d, expected code=%0d q=%0d raw=%h ch=%0d",
                             got.code, $signed(got.quant), got.raw, got.ch,
                             e.code, $signed(e.quant), e.raw, e.ch);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic bs, logic [1:0] ch, logic [1:0] md, logic [31:0] data);
        in_block_start = bs;
        in_ch          = ch;
        mode           = md;
        in_data        = data;
        in_valid       = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (took) break;
        end
        if (!took) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: sample not accepted, got in_ready=%0d expected 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int     sent;
        int     base;
        int     k;
        longint delta;
        longint lvl [NCH];
        res_t   last;

        rst = 1'b1;
        mode = 2'b01;
        in_valid = 1'b0;
        in_data = '0;
        in_ch = '0;
        in_block_start = 1'b0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        hold_prev = 1'b0;
        took = 1'b0;
        model_reset();
        for (int i = 0; i < NCH; i++) lvl[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_code",  64'(out_code),  64'd0);
        check("rst_out_quant", 64'(out_quant), 64'd0);
        check("rst_out_raw",   64'(out_raw),   64'd0);
        check("rst_cnt",       64'(cnt_unpred), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed table, applied back-to-back
        add(1, 0, 1, 100,  0, 3, 0);
        add(0, 0, 1, 110,  0, 0, 0);
        add(1, 1, 1, -100, 0, -3, 0);
        add(1, 0, 1, 0,    0, 0, 0);
        add(0, 0, 1, 32'h4000_0000, 1, 0, 32'h4000_0000);
        add(1, 0, 2, 0,  0, 0, 0);
        add(0, 0, 2, 32, 0, 1, 0);
        add(0, 0, 2, 64, 0, 0, 0);
        add(0, 0, 2, 96, 0, 0, 0);
        add(0, 1, 0, 32'h1234_5678, 2, 0, 32'h1234_5678);
        add(0, 1, 3, -90, 0, 0, 0);
        add(1, 2, 2, 0,  0, 0, 0);
        add(1, 3, 2, 0,  0, 0, 0);
        add(0, 2, 2, 32, 0, 1, 0);
        add(0, 3, 2, 32, 0, 1, 0);
        add(0, 2, 2, 64, 0, 0, 0);
        add(0, 3, 2, 64, 0, 0, 0);
        add(0, 2, 2, 96, 0, 0, 0);
        add(0, 3, 2, 96, 0, 0, 0);
        add(1, 3, 1, 1048528,      0, 32767, 0);
        add(1, 3, 1, 1048560,      1, 0, 32'h000F_FFF0);
        add(1, 3, 1, 32'hFFF0_0010, 0, -32767, 0);
        add(1, 3, 1, 32'hFFF0_000F, 1, 0, 32'hFFF0_000F);

        obs_q.delete();
        foreach (tbl[i]) send(tbl[i].bs, tbl[i].ch, tbl[i].md, tbl[i].data);
        drain();
        check("table_count", 64'(obs_q.size()), 64'(tbl.size()));
        foreach (tbl[i]) begin
            if (i < obs_q.size()) begin
                n_vec++;
                if (obs_q[i] !== {tbl[i].code, tbl[i].quant, tbl[i].raw, tbl[i].ch}) begin
                    n_err++;
                    $display("FAIL table[%0d]: got code=%0d q=%0d raw=%h, expected code=%0d q=%0d raw=%h",
                             i, obs_q[i].code, $signed(obs_q[i].quant), obs_q[i].raw,
                             tbl[i].code, $signed(tbl[i].quant), tbl[i].raw);
                end
            end
        end
        check("cnt_after_table", 64'(cnt_unpred), 64'd3);

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        m_cnt = 0;
        check("cnt_clr", 64'(cnt_unpred), 64'd0);

        // 10-sample burst with a 5-cycle output stall
        sent = 0;
        base = obs_q.size();
        for (int c = 0; c < 80; c++) begin
            out_ready      = !(c >= 3 && c < 8);
            in_valid       = (sent < 10);
            in_ch          = 2'd1;
            mode           = 2'b01;
            in_block_start = (sent == 0);
            in_data        = 32'(1000 + sent * 37);
            #1;
            if (c == 6 || c == 7) check("in_ready_stalled", 64'(in_ready), 64'd0);
            tick();
            if (took) sent++;
            if (sent == 10 && c >= 8 && exp_q.size() == 0 && !out_valid) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("burst_sent", 64'(sent), 64'd10);
        check("burst_count", 64'(obs_q.size() - base), 64'd10);

        // Randomized traffic against the reference model
        in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || took) begin
                in_valid       = ($urandom_range(0, 3) != 0);
                in_ch          = 2'($urandom_range(0, 3));
                mode           = 2'($urandom_range(0, 3));
                in_block_start = ($urandom_range(0, 15) == 0);
                k = int'($urandom_range(0, 9));
                if (k == 0) begin
                    in_data = $urandom();
                end else begin
                    if (k == 1) delta = longint'($urandom_range(0, 4194304)) - 2097152;
                    else        delta = longint'($urandom_range(0, 600)) - 300;
                    in_data = 32'(lvl[in_ch] + delta);
                end
                lvl[in_ch] = longint'($signed(in_data));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        check("cnt_after_random", 64'(cnt_unpred), 64'(m_cnt));

        // Reset with both stages full
        out_ready = 1'b0;
        send(1'b0, 2'd0, 2'b01, 32'd500);
        send(1'b0, 2'd1, 2'b01, 32'd700);
        check("preload_out_valid", 64'(out_valid), 64'd1);
        check("preload_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", 64'(out_valid), 64'd0);
        check("rst_async_cnt", 64'(cnt_unpred), 64'd0);
        exp_q.delete();
        model_reset();
        hold_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst2", 64'(in_ready), 64'd1);
        tick();
        check("no_output_after_rst", 64'(out_valid), 64'd0);
        base = obs_q.size();
        send(1'b1, 2'd2, 2'b01, 32'd50);
        send(1'b0, 2'd3, 2'b01, 32'd40);
        drain();
        check("post_rst_count", 64'(obs_q.size() - base), 64'd2);
        if (obs_q.size() >= base + 2) begin
            last = obs_q[base];
            check("post_rst_bs_result", 64'(last), 64'({2'b00, 16'd2, 32'd0, 2'd2}));
            last = obs_q[base + 1];
            check("post_rst_hist_clear", 64'(last), 64'({2'b00, 16'd1, 32'd0, 2'd3}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
